// File: rtl/a5_pc_sequencer_if.sv
// Command/status bundle between an instruction decoder and the PC sequencer.
// The master side issues commands and the slave side (the sequencer) reports PC and stack state.
interface a5_pc_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int FLAG_W = 2,
    parameter int SP_W   = 4
);
    logic              adv_i;
    logic [2:0]        cmd_i;
    logic [ADDR_W-1:0] target_i;
    logic              zero_i;
    logic              carry_i;
    logic              irq_i;
    logic              ien_i;
    logic [ADDR_W-1:0] pc_limit_i;

    logic [ADDR_W-1:0] pc_o;
    logic [SP_W-1:0]   sp_o;
    logic              stack_full_o;
    logic              stack_empty_o;
    logic              irq_ack_o;
    logic [FLAG_W-1:0] flags_out_o;
    logic              flags_valid_o;
    logic              in_isr_o;
    logic              halted_o;
    logic              fault_o;

    modport master (
        output adv_i, cmd_i, target_i, zero_i, carry_i, irq_i, ien_i, pc_limit_i,
        input  pc_o, sp_o, stack_full_o, stack_empty_o, irq_ack_o,
        input  flags_out_o, flags_valid_o, in_isr_o, halted_o, fault_o
    );

    modport slave (
        input  adv_i, cmd_i, target_i, zero_i, carry_i, irq_i, ien_i, pc_limit_i,
        output pc_o, sp_o, stack_full_o, stack_empty_o, irq_ack_o,
        output flags_out_o, flags_valid_o, in_isr_o, halted_o, fault_o
    );
endinterface

// File: rtl/a5_pc_sequencer.sv
// Program counter sequencer with a return stack of {flags,PC} entries and interrupt entry.
// HALTED/FAULT are sticky and freeze all state until reset.
module a5_pc_sequencer #(
    parameter int                ADDR_W       = 12,
    parameter int                DEPTH        = 8,
    parameter int                FLAG_W       = 2,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = 'h010,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    a5_pc_sequencer_if.slave  bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int SP_W    = IDX_W + 1;
    localparam int ENTRY_W = ADDR_W + FLAG_W;

    typedef enum logic [2:0] {
        CMD_NEXT = 3'd0,
        CMD_JMP  = 3'd1,
        CMD_JZ   = 3'd2,
        CMD_JC   = 3'd3,
        CMD_CALL = 3'd4,
        CMD_RET  = 3'd5,
        CMD_RETI = 3'd6,
        CMD_NOP  = 3'd7
    } cmd_e;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               in_isr_q, in_isr_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic               irq_ack_q, irq_ack_d;
    logic [FLAG_W-1:0]  flags_out_q, flags_out_d;
    logic               flags_valid_q, flags_valid_d;
    logic [ENTRY_W-1:0] stack_q [DEPTH];

    cmd_e               cmd;
    logic [FLAG_W-1:0]  cur_flags;
    logic               full, empty, at_limit, irq_take;
    logic [ADDR_W-1:0]  pc_inc, pc_step;
    logic [ENTRY_W-1:0] top_entry;
    logic               push_en;
    logic [ENTRY_W-1:0] push_data;

    assign cmd       = cmd_e'(bus.cmd_i);
    assign cur_flags = FLAG_W'({bus.carry_i, bus.zero_i});
    assign full      = (sp_q == SP_W'(DEPTH));
    assign empty     = (sp_q == '0);
    assign pc_inc    = pc_q + 1'b1;
    assign at_limit  = (pc_q == bus.pc_limit_i);
    assign pc_step   = at_limit ? pc_q : pc_inc;
    assign top_entry = stack_q[IDX_W'(sp_q - 1'b1)];
    assign irq_take  = bus.irq_i & bus.ien_i & ~in_isr_q & ~full;

    // Interrupt entry outranks the strobed command; the discarded command's PC is the one saved.
    always_comb begin
        pc_d          = pc_q;
        sp_d          = sp_q;
        in_isr_d      = in_isr_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        irq_ack_d     = 1'b0;
        flags_out_d   = flags_out_q;
        flags_valid_d = 1'b0;
        push_en       = 1'b0;
        push_data     = {cur_flags, pc_q};
        if (!(halted_q || fault_q)) begin
            if (irq_take) begin
                push_en   = 1'b1;
                sp_d      = sp_q + 1'b1;
                pc_d      = IRQ_VECTOR;
                in_isr_d  = 1'b1;
                irq_ack_d = 1'b1;
            end else if (bus.adv_i) begin
                case (cmd)
                    CMD_NEXT: begin
                        pc_d     = pc_step;
                        halted_d = at_limit;
                    end
                    CMD_JMP: pc_d = bus.target_i;
                    CMD_JZ, CMD_JC: begin
                        if ((cmd == CMD_JZ) ? bus.zero_i : bus.carry_i) begin
                            pc_d = bus.target_i;
                        end else begin
                            pc_d     = pc_step;
                            halted_d = at_limit;
                        end
                    end
                    CMD_CALL: begin
                        if (full) begin
                            fault_d = 1'b1;
                        end else begin
                            push_en   = 1'b1;
                            push_data = {cur_flags, pc_inc};
                            sp_d      = sp_q + 1'b1;
                            pc_d      = bus.target_i;
                        end
                    end
                    CMD_RET, CMD_RETI: begin
                        if (empty) begin
                            fault_d = 1'b1;
                        end else begin
                            sp_d = sp_q - 1'b1;
                            pc_d = top_entry[ADDR_W-1:0];
                            if (cmd == CMD_RETI) begin
                                in_isr_d      = 1'b0;
                                flags_out_d   = top_entry[ENTRY_W-1:ADDR_W];
                                flags_valid_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            sp_q          <= '0;
            in_isr_q      <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            irq_ack_q     <= 1'b0;
            flags_out_q   <= '0;
            flags_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            sp_q          <= sp_d;
            in_isr_q      <= in_isr_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            irq_ack_q     <= irq_ack_d;
            flags_out_q   <= flags_out_d;
            flags_valid_q <= flags_valid_d;
        end
    end

    // Stack RAM has no reset; gating on rst keeps an edge taken during reset from leaving a partial push.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            stack_q[IDX_W'(sp_q)] <= push_data;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.sp_o          = sp_q;
    assign bus.stack_full_o  = full;
    assign bus.stack_empty_o = empty;
    assign bus.irq_ack_o     = irq_ack_q;
    assign bus.flags_out_o   = flags_out_q;
    assign bus.flags_valid_o = flags_valid_q;
    assign bus.in_isr_o      = in_isr_q;
    assign bus.halted_o      = halted_q;
    assign bus.fault_o       = fault_q;
endmodule

// File: tb/tb_a5_pc_sequencer.sv
// Directed bench for a5_pc_sequencer: each step queues its expected state, which is popped and checked after the edge.
// Status vector order is {in_isr, halted, fault, irq_ack, flags_valid, stack_full, stack_empty}.
module tb_a5_pc_sequencer;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;
    localparam int FLAG_W = 2;
    localparam int SP_W   = 4;

    localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, JZ = 3'd2, JC = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, RETI = 3'd6, NOP = 3'd7;

    typedef struct {
        string       tag;
        logic [11:0] pc;
        logic [3:0]  sp;
        logic [6:0]  st;
        logic [1:0]  fo;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    a5_pc_sequencer_if #(.ADDR_W(ADDR_W), .FLAG_W(FLAG_W), .SP_W(SP_W)) bus ();

    a5_pc_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FLAG_W(FLAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t mk(string tag, logic [11:0] pc, logic [3:0] sp,
                                logic [6:0] st, logic [1:0] fo);
        exp_t e;
        e.tag = tag;
        e.pc  = pc;
        e.sp  = sp;
        e.st  = st;
        e.fo  = fo;
        return e;
    endfunction

    task automatic cmp(string tag, string field, logic [31:0] obs, logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sbq.pop_front();
            cmp(e.tag, "pc", 32'(bus.pc_o), 32'(e.pc));
            cmp(e.tag, "sp", 32'(bus.sp_o), 32'(e.sp));
            cmp(e.tag, "status",
                32'({bus.in_isr_o, bus.halted_o, bus.fault_o, bus.irq_ack_o,
                     bus.flags_valid_o, bus.stack_full_o, bus.stack_empty_o}), 32'(e.st));
            cmp(e.tag, "flags", 32'(bus.flags_out_o), 32'(e.fo));
        end
    endtask

    // Called away from the clock edge; the next rising edge acts on the driven inputs.
    task automatic applyStimulus(input logic adv, input logic [2:0] cmd, input logic [11:0] tgt,
                                 input logic z, input logic c, input logic irq, input exp_t e);
        bus.adv_i    = adv;
        bus.cmd_i    = cmd;
        bus.target_i = tgt;
        bus.zero_i   = z;
        bus.carry_i  = c;
        bus.irq_i    = irq;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset is raised mid-cycle and checked before the next edge, then released just before that edge.
    task automatic doReset(input logic [11:0] lim);
        @(negedge clk);
        #2;
        rst            = 1'b1;
        bus.adv_i      = 1'b0;
        bus.irq_i      = 1'b0;
        bus.zero_i     = 1'b0;
        bus.carry_i    = 1'b0;
        bus.pc_limit_i = lim;
        #1;
        sbq.push_back(mk("reset", 12'h000, 4'd0, 7'b0000001, 2'b00));
        checkOutput();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.adv_i      = 1'b0;
        bus.cmd_i      = NOP;
        bus.target_i   = '0;
        bus.zero_i     = 1'b0;
        bus.carry_i    = 1'b0;
        bus.irq_i      = 1'b0;
        bus.ien_i      = 1'b1;
        bus.pc_limit_i = 12'hFFF;

        // Sequential advance up to PC_LIMIT, then halt freezes even JMP and IRQ.
        doReset(12'h003);
        for (int i = 1; i <= 3; i++)
            applyStimulus(1, NXT, 0, 0, 0, 0, mk("next", 12'(i), 4'd0, 7'b0000001, 2'b00));
        applyStimulus(1, NXT, 0, 0, 0, 0, mk("next_limit", 12'h003, 4'd0, 7'b0100001, 2'b00));
        applyStimulus(1, JMP, 12'h100, 0, 0, 1, mk("halt_frozen", 12'h003, 4'd0, 7'b0100001, 2'b00));

        doReset(12'hFFF);
        applyStimulus(1, JMP, 12'h005, 0, 0, 0, mk("jmp5", 12'h005, 4'd0, 7'b0000001, 2'b00));
        applyStimulus(1, CALL, 12'h100, 0, 0, 0, mk("call", 12'h100, 4'd1, 7'b0000000, 2'b00));
        applyStimulus(1, RET, 0, 0, 0, 0, mk("ret", 12'h006, 4'd0, 7'b0000001, 2'b00));

        // Fill the stack, defer an IRQ while full, then overflow into FAULT.
        doReset(12'hFFF);
        for (int i = 0; i < 8; i++)
            applyStimulus(1, CALL, 12'(12'h200 + i), 0, 0, 0,
                          mk("fill", 12'(12'h200 + i), 4'(i + 1), (i == 7) ? 7'b0000010 : 7'b0000000, 2'b00));
        applyStimulus(0, NOP, 0, 0, 0, 1, mk("irq_deferred", 12'h207, 4'd8, 7'b0000010, 2'b00));
        applyStimulus(1, RET, 0, 0, 0, 1, mk("ret_frees", 12'h207, 4'd7, 7'b0000000, 2'b00));
        applyStimulus(0, NOP, 0, 0, 0, 1, mk("irq_late", 12'h010, 4'd8, 7'b1001010, 2'b00));
        applyStimulus(1, RETI, 0, 0, 0, 0, mk("reti_late", 12'h207, 4'd7, 7'b0000100, 2'b00));
        applyStimulus(1, CALL, 12'h300, 0, 0, 0, mk("refill", 12'h300, 4'd8, 7'b0000010, 2'b00));
        applyStimulus(1, CALL, 12'h301, 0, 0, 0, mk("overflow", 12'h300, 4'd8, 7'b0010010, 2'b00));
        applyStimulus(1, NXT, 0, 0, 0, 1, mk("fault_frozen", 12'h300, 4'd8, 7'b0010010, 2'b00));

        // Interrupt beats a concurrent JMP; RETI restores {CARRY,ZERO}=10.
        doReset(12'hFFF);
        applyStimulus(1, JMP, 12'h020, 0, 0, 0, mk("jmp20", 12'h020, 4'd0, 7'b0000001, 2'b00));
        applyStimulus(1, JMP, 12'h555, 0, 1, 1, mk("irq_entry", 12'h010, 4'd1, 7'b1001000, 2'b00));
        applyStimulus(1, NXT, 0, 0, 0, 1, mk("isr_next", 12'h011, 4'd1, 7'b1000000, 2'b00));
        applyStimulus(1, RETI, 0, 0, 0, 0, mk("reti", 12'h020, 4'd0, 7'b0000101, 2'b10));
        applyStimulus(1, NOP, 0, 0, 0, 0, mk("fv_drop", 12'h020, 4'd0, 7'b0000001, 2'b10));
        bus.ien_i = 1'b0;
        applyStimulus(1, NXT, 0, 0, 0, 1, mk("ien_off", 12'h021, 4'd0, 7'b0000001, 2'b10));
        bus.ien_i = 1'b1;
        applyStimulus(1, JZ, 12'h040, 1, 0, 0, mk("jz_taken", 12'h040, 4'd0, 7'b0000001, 2'b10));
        applyStimulus(1, JC, 12'h777, 0, 0, 0, mk("jc_not", 12'h041, 4'd0, 7'b0000001, 2'b10));
        applyStimulus(1, JC, 12'h080, 0, 1, 0, mk("jc_taken", 12'h080, 4'd0, 7'b0000001, 2'b10));
        applyStimulus(1, JZ, 12'h777, 0, 1, 0, mk("jz_not", 12'h081, 4'd0, 7'b0000001, 2'b10));
        applyStimulus(0, JMP, 12'h777, 0, 0, 0, mk("adv_low", 12'h081, 4'd0, 7'b0000001, 2'b10));
        applyStimulus(1, CALL, 12'h090, 1, 0, 0, mk("call_z", 12'h090, 4'd1, 7'b0000000, 2'b10));
        applyStimulus(1, RETI, 0, 0, 0, 0, mk("reti_noisr", 12'h082, 4'd0, 7'b0000101, 2'b01));
        applyStimulus(1, RET, 0, 0, 0, 0, mk("ret_empty", 12'h082, 4'd0, 7'b0010001, 2'b01));
        applyStimulus(1, NXT, 0, 0, 0, 0, mk("fault_hold", 12'h082, 4'd0, 7'b0010001, 2'b01));

        // Untaken branch at the limit halts; with PC_LIMIT=0 the top address wraps to zero.
        doReset(12'hFFF);
        applyStimulus(1, JMP, 12'hFFF, 0, 0, 0, mk("jmp_top", 12'hFFF, 4'd0, 7'b0000001, 2'b00));
        applyStimulus(1, JZ, 12'h123, 0, 0, 0, mk("jz_halt", 12'hFFF, 4'd0, 7'b0100001, 2'b00));
        doReset(12'h000);
        applyStimulus(1, JMP, 12'hFFF, 0, 0, 0, mk("jmp_top2", 12'hFFF, 4'd0, 7'b0000001, 2'b00));
        applyStimulus(1, NXT, 0, 0, 0, 0, mk("wrap", 12'h000, 4'd0, 7'b0000001, 2'b00));
        applyStimulus(1, NXT, 0, 0, 0, 0, mk("halt_zero", 12'h000, 4'd0, 7'b0100001, 2'b00));

        // Asynchronous reset in the middle of an ISR, then the very next edge executes a command.
        doReset(12'hFFF);
        applyStimulus(1, JMP, 12'h020, 0, 0, 0, mk("jmp20b", 12'h020, 4'd0, 7'b0000001, 2'b00));
        applyStimulus(0, NOP, 0, 0, 0, 1, mk("irq_entry2", 12'h010, 4'd1, 7'b1001000, 2'b00));
        applyStimulus(1, NXT, 0, 0, 0, 1, mk("in_isr", 12'h011, 4'd1, 7'b1000000, 2'b00));
        doReset(12'hFFF);
        applyStimulus(1, NXT, 0, 0, 0, 0, mk("first_cmd", 12'h001, 4'd0, 7'b0000001, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/a5_pc_sequencer.md
A5_PC_SEQUENCER -- requirements
Module: a5_pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, program-address width.
REQ-002 SHALL have parameter DEPTH, default 8, return-stack entries (power of two, >=2).
REQ-003 SHALL have parameter FLAG_W, default 2, saved flag width ({CARRY,ZERO}).
REQ-004 SHALL have parameter IRQ_VECTOR, default 'h010, ADDR_W-bit interrupt entry address.
REQ-005 SHALL have parameter RESET_VECTOR, default 0, ADDR_W-bit PC after reset.
REQ-006 CLK  in  1  single clock, all state on rising edge.
REQ-007 RST  in  1  reset, asynchronous, active-high.
REQ-008 ADV  in  1  command strobe; CMD is acted on only when ADV=1.
REQ-009 CMD  in  3  0 NEXT, 1 JMP, 2 JZ, 3 JC, 4 CALL, 5 RET, 6 RETI, 7 NOP(hold).
REQ-010 TARGET  in  ADDR_W  jump/call destination.
REQ-011 ZERO, CARRY  in  1 each  ALU flags, sampled on the ADV cycle.
REQ-012 IRQ  in  1  level interrupt request; IEN  in  1  global interrupt enable.
REQ-013 PC_LIMIT  in  ADDR_W  last executable address.
REQ-014 PC  out  ADDR_W  current program address (registered).
REQ-015 SP  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-016 STACK_FULL, STACK_EMPTY  out  1 each  SP==DEPTH, SP==0 (combinational from SP).
REQ-017 IRQ_ACK  out  1  one-cycle pulse on the interrupt-entry cycle.
REQ-018 FLAGS_OUT  out  FLAG_W; FLAGS_VALID  out  1  flags restored by RETI, one-cycle pulse.
REQ-019 IN_ISR, HALTED, FAULT  out  1 each  status, all registered.

Function
REQ-020 SHALL hold stack entries of ADDR_W+FLAG_W bits; SP counts up on push, down on pop; no wrap.
REQ-021 Per-edge priority SHALL be: RST > HALTED/FAULT (freeze) > interrupt entry > ADV command > hold.
REQ-022 Interrupt entry SHALL occur when IRQ & IEN & ~IN_ISR & ~STACK_FULL & ~HALTED: push {flags,PC}, PC<=IRQ_VECTOR, IN_ISR<=1, IRQ_ACK=1; a coincident ADV command SHALL be discarded (the PC pushed is the unexecuted PC).
REQ-023 IRQ with STACK_FULL SHALL be deferred (no fault) until a pop frees an entry.
REQ-024 NEXT: PC<=PC+1 modulo 2^ADDR_W; if PC==PC_LIMIT, PC holds and HALTED<=1.
REQ-025 JMP: PC<=TARGET; JZ/JC: PC<=TARGET if ZERO/CARRY=1, else PC+1 with REQ-024 limit rule.
REQ-026 CALL: push {flags,PC+1}, PC<=TARGET; if STACK_FULL, no push, PC holds, FAULT<=1.
REQ-027 RET: pop, PC<=entry address field; if STACK_EMPTY, PC holds, FAULT<=1.
REQ-028 RETI: as RET plus IN_ISR<=0, FLAGS_OUT<=entry flag field, FLAGS_VALID=1 next cycle; RETI with IN_ISR=0 SHALL still pop (no fault) but leave IN_ISR 0.
REQ-029 NOP or ADV=0: all state holds.
REQ-030 HALTED and FAULT SHALL be sticky; once set, PC, SP, stack contents freeze and IRQ is ignored until RST.
REQ-031 Latency: every PC update SHALL be visible on PC one cycle after the deciding edge; no bubbles.

Reset
REQ-032 RST=1 SHALL immediately set PC=RESET_VECTOR, SP=0, IN_ISR=HALTED=FAULT=IRQ_ACK=FLAGS_VALID=0, FLAGS_OUT=0; stack RAM contents undefined.
REQ-033 Reset asserted mid-CALL/interrupt entry SHALL abort it with no partial push.
REQ-034 First command SHALL be accepted on the first rising edge after RST deasserts.

Verification
REQ-035 Reset, 4x ADV/NEXT, PC_LIMIT=3 -> PC 0,1,2,3,3; HALTED=1 after the 4th strobe.
REQ-036 CALL TARGET=0x100 at PC=0x005, then RET -> PC=0x100, SP=1; then PC=0x006, SP=0, STACK_EMPTY=1.
REQ-037 DEPTH=8: 8 CALLs then a 9th -> STACK_FULL=1, 9th leaves PC/SP unchanged, FAULT=1, subsequent commands ignored.
REQ-038 PC=0x020, CARRY=1 ZERO=0, IRQ=IEN=1 with concurrent ADV JMP -> IRQ_ACK pulse, PC=0x010, IN_ISR=1; RETI -> PC=0x020, FLAGS_OUT=2'b10, FLAGS_VALID pulse, IN_ISR=0.
REQ-039 RET on empty stack -> FAULT=1, PC held; JZ with ZERO=0 at PC=0xFFF, PC_LIMIT=0xFFF -> HALTED=1; PC_LIMIT=0x000 from PC=0xFFF NEXT -> PC=0x000 (wrap).
REQ-040 RST pulsed asynchronously between edges during an ISR -> outputs reach reset values before next edge; SP=0.
